// File: rtl/jt51_pkg.sv
// Shared constants, types and the PMS scaling table for the JT51 pitch-modulation path.
package jt51_pkg;

  localparam int unsigned LIN_W         = 13;
  localparam int unsigned LIN_MAX       = 6143;
  localparam int unsigned NOTES_PER_OCT = 12;

  typedef logic [LIN_W-1:0] lin_t;

  // Stage I payload: linear pitch plus signed PM offset
  typedef struct packed {
    lin_t       lin;
    logic       neg;
    logic [7:0] d;
  } pm_stage1_t;

  // Scale the 7-bit PM magnitude by the channel PMS setting
  function automatic logic [7:0] pms_scale(input logic [2:0] pms, input logic [6:0] m);
    case (pms)
      3'd0:    pms_scale = 8'd0;
      3'd1:    pms_scale = 8'(m >> 5);
      3'd2:    pms_scale = 8'(m >> 4);
      3'd3:    pms_scale = 8'(m >> 3);
      3'd4:    pms_scale = 8'(m >> 2);
      3'd5:    pms_scale = 8'(m >> 1);
      3'd6:    pms_scale = {1'b0, m};
      default: pms_scale = {m, 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/jt51_pm_apply_if.sv
// Slot-multiplexed pitch bus between the slot sequencer and the PM applicator.
interface jt51_pm_apply_if;

  logic       cen;
  logic [4:0] cycles;
  logic [7:0] pm;
  logic [6:0] kc_I;
  logic [5:0] kf_I;
  logic [2:0] pms_I;
  logic [6:0] kc_III;
  logic [5:0] kf_III;

  modport master (
    output cen, cycles, pm, kc_I, kf_I, pms_I,
    input  kc_III, kf_III
  );

  modport slave (
    input  cen, cycles, pm, kc_I, kf_I, pms_I,
    output kc_III, kf_III
  );

endinterface

// File: rtl/jt51_pm_kc2lin.sv
// Combinational KC/KF <-> linear pitch converter: forward half feeds stage I,
// reverse half turns the stage II sum back into a gapped key code for stage III.
module jt51_pm_kc2lin
  import jt51_pkg::*;
(
  input  logic [6:0] kc_fwd,
  input  logic [5:0] kf_fwd,
  output lin_t       lin_fwd_c,
  input  lin_t       lin_rev,
  output logic [6:0] kc_rev_c,
  output logic [5:0] kf_rev_c
);

  logic [3:0] n_fwd;
  logic [6:0] note_fwd;
  logic [6:0] note_rev;
  logic [2:0] oct_rev;
  logic [3:0] n_rev;
  logic [3:0] gap_rev;

  // Forward: squeeze out the unused note codes, then oct*12 + n
  always_comb begin
    n_fwd     = kc_fwd[3:0] - {2'b00, kc_fwd[3:2]};
    note_fwd  = 7'({kc_fwd[6:4], 3'b000}) + 7'({kc_fwd[6:4], 2'b00}) + 7'(n_fwd);
    lin_fwd_c = {note_fwd, kf_fwd};
  end

  // Reverse: octave by compare ladder, then reinsert one gap per three notes
  always_comb begin
    note_rev = lin_rev[12:6];
    oct_rev  = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (note_rev >= 7'(i * NOTES_PER_OCT)) oct_rev = 3'(i);
    end
    n_rev    = 4'(note_rev - 7'({oct_rev, 3'b000}) - 7'({oct_rev, 2'b00}));
    gap_rev  = (n_rev >= 4'd9) ? 4'd3 :
               (n_rev >= 4'd6) ? 4'd2 :
               (n_rev >= 4'd3) ? 4'd1 : 4'd0;
    kc_rev_c = {oct_rev, n_rev + gap_rev};
    kf_rev_c = lin_rev[5:0];
  end

endmodule

// File: rtl/jt51_pm_apply.sv
// Applies the frame-latched LFO PM word to each slot's KC/KF over a 3-stage pipeline.
// Build option JT51_PM_CLAMP_EN: saturate out-of-range pitch instead of wrapping it.
module jt51_pm_apply
  import jt51_pkg::*;
(
  input  logic           rst,
  input  logic           clk,
  jt51_pm_apply_if.slave bus
);

  logic [7:0]  pm_l;
  pm_stage1_t  st1;
  lin_t        s2;
  lin_t        lin_c;
  lin_t        s_c;
  logic [6:0]  kc_c;
  logic [5:0]  kf_c;
  logic [13:0] sum_c;

  jt51_pm_kc2lin u_conv (
    .kc_fwd    (bus.kc_I),
    .kf_fwd    (bus.kf_I),
    .lin_fwd_c (lin_c),
    .lin_rev   (s2),
    .kc_rev_c  (kc_c),
    .kf_rev_c  (kf_c)
  );

  // Stage II arithmetic: 14-bit two's complement, bit 13 flags a negative result
  always_comb begin
    sum_c = st1.neg ? ({1'b0, st1.lin} - {6'd0, st1.d})
                    : ({1'b0, st1.lin} + {6'd0, st1.d});
`ifdef JT51_PM_CLAMP_EN
    if (sum_c[13])                    s_c = '0;
    else if (sum_c > 14'(LIN_MAX))    s_c = LIN_W'(LIN_MAX);
    else                              s_c = sum_c[12:0];
`else
    if (sum_c[13])                    s_c = LIN_W'(sum_c + 14'(LIN_MAX + 1));
    else if (sum_c > 14'(LIN_MAX))    s_c = LIN_W'(sum_c - 14'(LIN_MAX + 1));
    else                              s_c = sum_c[12:0];
`endif
  end

  // Slot 31 refreshes pm_l after its own use, so a whole frame sees one value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pm_l       <= '0;
      st1        <= '0;
      s2         <= '0;
      bus.kc_III <= '0;
      bus.kf_III <= '0;
    end else if (bus.cen) begin
      if (bus.cycles == 5'd31) pm_l <= bus.pm;
      st1.lin    <= lin_c;
      st1.neg    <= pm_l[7];
      st1.d      <= pms_scale(bus.pms_I, pm_l[6:0]);
      s2         <= s_c;
      bus.kc_III <= kc_c;
      bus.kf_III <= kf_c;
    end
  end

endmodule

// File: tb/tb_jt51_pm_apply.sv
// Bench for jt51_pm_apply: arithmetic pitch model checked every cycle plus literal vectors.
module tb_jt51_pm_apply;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jt51_pm_apply_if bus();

  jt51_pm_apply dut (
    .rst (rst),
    .clk (clk),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  int note_code [12] = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 12, 13, 14};

  // Expected {kc, kf} from octave/semitone arithmetic on plain integers
  function automatic logic [12:0] expect_pitch(input int kc, input int kf, input int pms, input int pm);
    int oct, code, lin, m, d, s, note;
    oct  = kc / 16;
    code = kc % 16;
    lin  = (oct * 12 + code - code / 4) * 64 + kf;
    m    = pm % 128;
    case (pms)
      0:       d = 0;
      1:       d = m / 32;
      2:       d = m / 16;
      3:       d = m / 8;
      4:       d = m / 4;
      5:       d = m / 2;
      6:       d = m;
      default: d = m * 2;
    endcase
    s = (pm >= 128) ? lin - d : lin + d;
`ifdef JT51_PM_CLAMP_EN
    if (s < 0)    s = 0;
    if (s > 6143) s = 6143;
`else
    if (s < 0)         s = s + 6144;
    else if (s > 6143) s = s - 6144;
`endif
    note = s / 64;
    return {3'(note / 12), 4'(note_code[note % 12]), 6'(s % 64)};
  endfunction

  // Model: result for the slot sampled at an enabled edge emerges two enabled edges later
  logic [12:0] m_q0, m_q1, m_out;
  logic [7:0]  m_pm_l;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q0 = '0; m_q1 = '0; m_out = '0; m_pm_l = '0;
    end else if (bus.cen) begin
      m_out = m_q1;
      m_q1  = m_q0;
      m_q0  = expect_pitch(int'(bus.kc_I), int'(bus.kf_I), int'(bus.pms_I), int'(m_pm_l));
      if (bus.cycles == 5'd31) m_pm_l = bus.pm;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if ({bus.kc_III, bus.kf_III} !== m_out) begin
        failures++;
        $display("FAIL model_cmp t=%0t cycles=%0d got kc=%h kf=%0d want kc=%h kf=%0d",
                 $time, bus.cycles, bus.kc_III, bus.kf_III, m_out[12:6], m_out[5:0]);
      end
    end
  end

  task automatic check_lit(input string name, input logic [6:0] ekc, input logic [5:0] ekf);
    checks++;
    if (bus.kc_III !== ekc || bus.kf_III !== ekf) begin
      failures++;
      $display("FAIL %s got kc=%h kf=%0d want kc=%h kf=%0d", name, bus.kc_III, bus.kf_III, ekc, ekf);
    end
  endtask

  task automatic step(input bit en);
    bus.cen = en;
    @(negedge clk);
    if (en) bus.cycles = bus.cycles + 5'd1;
  endtask

  task automatic latch_pm(input logic [7:0] p);
    bus.pm = p;
    while (bus.cycles != 5'd31) step(1'b1);
    step(1'b1);
  endtask

  task automatic set_slot(input logic [2:0] pms, input logic [6:0] kc, input logic [5:0] kf);
    bus.pms_I = pms;
    bus.kc_I  = kc;
    bus.kf_I  = kf;
  endtask

  task automatic run_vec(input string name, input logic [2:0] pms, input logic [7:0] p,
                         input logic [6:0] kc, input logic [5:0] kf,
                         input logic [6:0] ekc, input logic [5:0] ekf);
    latch_pm(p);
    set_slot(pms, kc, kf);
    repeat (3) step(1'b1);
    check_lit(name, ekc, ekf);
  endtask

  initial begin
    rst = 1'b1;
    bus.cen = 1'b0; bus.cycles = '0; bus.pm = '0;
    set_slot(3'd0, 7'h00, 6'd0);
    repeat (2) @(negedge clk);
    check_lit("reset", 7'h00, 6'd0);
    rst = 1'b0;
    chk_on = 1'b1;

    run_vec("pass_through", 3'd0, 8'h7F, 7'h4A, 6'd7,  7'h4A, 6'd7);
    run_vec("note_cross",   3'd6, 8'h40, 7'h4A, 6'd0,  7'h4C, 6'd0);
    run_vec("kf_offset",    3'd6, 8'h10, 7'h4A, 6'd0,  7'h4A, 6'd16);
    run_vec("neg_in_range", 3'd5, 8'hA0, 7'h4A, 6'd0,  7'h49, 6'd48);
    run_vec("unused_code",  3'd0, 8'h00, 7'h0F, 6'd0,  7'h10, 6'd0);
    run_vec("scale_pms1",   3'd1, 8'h3F, 7'h10, 6'd0,  7'h10, 6'd1);
`ifdef JT51_PM_CLAMP_EN
    run_vec("underflow",    3'd6, 8'h90, 7'h00, 6'd5,  7'h00, 6'd0);
    run_vec("overflow",     3'd7, 8'h7F, 7'h7E, 6'd63, 7'h7E, 6'd63);
`else
    run_vec("underflow",    3'd6, 8'h90, 7'h00, 6'd5,  7'h7E, 6'd53);
    run_vec("overflow",     3'd7, 8'h7F, 7'h7E, 6'd63, 7'h04, 6'd61);
`endif

    // Varied per-slot inputs over two frames, checked by the model only
    foreach (note_code[k]) begin end
    latch_pm(8'h90);
    for (int i = 0; i < 32; i++) begin
      set_slot(3'(i), 7'(i * 37 + 5), 6'(i * 11));
      step(1'b1);
    end
    latch_pm(8'hFF);
    for (int i = 0; i < 32; i++) begin
      set_slot(3'(7 - (i % 8)), 7'(i * 29 + 100), 6'(i * 7 + 3));
      step(1'b1);
    end

    // Latch coherency: a mid-frame pm change waits for the next frame
    latch_pm(8'h00);
    set_slot(3'd6, 7'h4A, 6'd0);
    while (bus.cycles != 5'd10) step(1'b1);
    bus.pm = 8'h40;
    while (bus.cycles != 5'd31) step(1'b1);
    repeat (3) step(1'b1);
    check_lit("coh_slot31_old", 7'h4A, 6'd0);
    step(1'b1);
    check_lit("coh_slot0_new", 7'h4C, 6'd0);

    // cen low: outputs frozen even though inputs change
    set_slot(3'd6, 7'h00, 6'd9);
    bus.pm = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      check_lit("cen_hold", 7'h4C, 6'd0);
    end
    repeat (4) step(1'b1);

    // Asynchronous reset mid-frame clears outputs and the latched pm
    while (bus.cycles != 5'd5) step(1'b1);
    #2 rst = 1'b1;
    #1 check_lit("rst_async", 7'h00, 6'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.pm = 8'h40;
    set_slot(3'd6, 7'h4A, 6'd0);
    repeat (3) step(1'b1);
    check_lit("rst_pm_zero", 7'h4A, 6'd0);
    latch_pm(8'h40);
    repeat (3) step(1'b1);
    check_lit("rst_relatch", 7'h4C, 6'd0);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
